// File: rtl/intx_timer_irq_ctrl.sv
// Interrupt controller: synchronised external lines (edge/level, polarity), compare timer,
// write-1-to-clear pending bits and a registered request to the core over a dual Wishbone port.
module intx_timer_irq_ctrl #(
    parameter int unsigned          NUM_INTX  = 4,
    parameter int unsigned          XLEN      = 32,
    parameter int unsigned          ADDR_BITS = 8,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR = 8'h10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync_reset,
    input  logic                  WB_RD_STB_I,
    input  logic [ADDR_BITS-1:0]  WB_RD_ADR_I,
    output logic [XLEN-1:0]       WB_RD_DAT_O,
    output logic                  WB_RD_ACK_O,
    input  logic                  WB_WR_STB_I,
    input  logic                  WB_WR_WE_I,
    input  logic [XLEN/8-1:0]     WB_WR_SEL_I,
    input  logic [ADDR_BITS-1:0]  WB_WR_ADR_I,
    input  logic [XLEN-1:0]       WB_WR_DAT_I,
    output logic                  WB_WR_ACK_O,
    input  logic [NUM_INTX-1:0]   INTx,
    output logic                  int_gen,
    output logic [NUM_INTX:0]     int_pending
);

    localparam int unsigned NI = NUM_INTX + 1;
    localparam int unsigned NB = XLEN / 8;

    logic [NUM_INTX-1:0] sync1_q, sync2_q, prev_lvl_q;
    logic [NUM_INTX-1:0] mode_q, mode_d, pol_q, pol_d;
    logic [NI-1:0]       pending_q, pending_d, enable_q, enable_d;
    logic [XLEN-1:0]     cnt_q, cnt_d, cmp_q, cmp_d;
    logic                run_q, run_d, auto_q, auto_d;
    logic                int_gen_q;
    logic [XLEN-1:0]     rd_dat_q, rd_val;
    logic                rd_ack_q, wr_ack_q;

    logic [NUM_INTX-1:0]  lvl, edge_set;
    logic [XLEN-1:0]      byte_mask, ctrl_wr;
    logic [NI-1:0]        clr;
    logic [ADDR_BITS-1:0] rd_off, wr_off;
    logic                 wr_fire, timer_hit;
    logic                 we_pend, we_en, we_mode, we_pol, we_cmp, we_ctrl;

    function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old,
                                              input logic [XLEN-1:0] wdat,
                                              input logic [XLEN-1:0] mask);
        return (old & ~mask) | (wdat & mask);
    endfunction

    assign lvl      = sync2_q ^ pol_q;
    assign edge_set = lvl & ~prev_lvl_q;

    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < NB; i++) begin
            byte_mask[8*i +: 8] = {8{WB_WR_SEL_I[i]}};
        end
    end

    // Write decode
    always_comb begin
        wr_off  = WB_WR_ADR_I - BASE_ADDR;
        wr_fire = WB_WR_STB_I && WB_WR_WE_I && (WB_WR_ADR_I >= BASE_ADDR)
                  && (wr_off < ADDR_BITS'(7));
        we_pend = wr_fire && (wr_off[2:0] == 3'd0);
        we_en   = wr_fire && (wr_off[2:0] == 3'd1);
        we_mode = wr_fire && (wr_off[2:0] == 3'd2);
        we_pol  = wr_fire && (wr_off[2:0] == 3'd3);
        we_cmp  = wr_fire && (wr_off[2:0] == 3'd5);
        we_ctrl = wr_fire && (wr_off[2:0] == 3'd6);
    end

    // Configuration registers, pending vector and timer next state
    always_comb begin
        enable_d  = enable_q;
        mode_d    = mode_q;
        pol_d     = pol_q;
        cmp_d     = cmp_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        auto_d    = auto_q;
        clr       = '0;
        pending_d = pending_q;
        ctrl_wr   = merge(XLEN'({auto_q, run_q}), WB_WR_DAT_I, byte_mask);

        if (we_en)   enable_d = NI'(merge(XLEN'(enable_q), WB_WR_DAT_I, byte_mask));
        if (we_mode) mode_d   = NUM_INTX'(merge(XLEN'(mode_q), WB_WR_DAT_I, byte_mask));
        if (we_pol)  pol_d    = NUM_INTX'(merge(XLEN'(pol_q), WB_WR_DAT_I, byte_mask));
        if (we_pend) clr      = NI'(WB_WR_DAT_I & byte_mask);

        timer_hit = run_q && (cnt_q == cmp_q);
        if (run_q) begin
            if (timer_hit) begin
                if (auto_q) cnt_d = '0;
                else        run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + XLEN'(1);
            end
        end
        if (we_cmp) begin
            cmp_d = merge(cmp_q, WB_WR_DAT_I, byte_mask);
            cnt_d = '0;
        end
        // A CTRL write overrides the one-shot auto-stop in the same cycle
        if (we_ctrl) begin
            run_d  = ctrl_wr[0];
            auto_d = ctrl_wr[1];
        end

        // Level channels follow lvl, so a clear never sticks; sets beat clears
        for (int i = 0; i < NUM_INTX; i++) begin
            if (mode_q[i]) pending_d[i] = (pending_q[i] & ~clr[i]) | edge_set[i];
            else           pending_d[i] = lvl[i];
        end
        pending_d[NUM_INTX] = (pending_q[NUM_INTX] & ~clr[NUM_INTX]) | timer_hit;
    end

    // Read mux
    always_comb begin
        rd_off = WB_RD_ADR_I - BASE_ADDR;
        rd_val = '0;
        if ((WB_RD_ADR_I >= BASE_ADDR) && (rd_off < ADDR_BITS'(7))) begin
            case (rd_off[2:0])
                3'd0:    rd_val[NI-1:0]       = pending_q;
                3'd1:    rd_val[NI-1:0]       = enable_q;
                3'd2:    rd_val[NUM_INTX-1:0] = mode_q;
                3'd3:    rd_val[NUM_INTX-1:0] = pol_q;
                3'd4:    rd_val               = cnt_q;
                3'd5:    rd_val               = cmp_q;
                3'd6:    rd_val[1:0]          = {auto_q, run_q};
                default: rd_val               = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_lvl_q <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            pol_q      <= '0;
            cnt_q      <= '0;
            cmp_q      <= '0;
            run_q      <= 1'b0;
            auto_q     <= 1'b0;
            int_gen_q  <= 1'b0;
            rd_dat_q   <= '0;
            rd_ack_q   <= 1'b0;
            wr_ack_q   <= 1'b0;
        end else if (sync_reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_lvl_q <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            pol_q      <= '0;
            cnt_q      <= '0;
            cmp_q      <= '0;
            run_q      <= 1'b0;
            auto_q     <= 1'b0;
            int_gen_q  <= 1'b0;
            rd_dat_q   <= '0;
            rd_ack_q   <= 1'b0;
            wr_ack_q   <= 1'b0;
        end else begin
            sync1_q    <= INTx;
            sync2_q    <= sync1_q;
            prev_lvl_q <= lvl;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            pol_q      <= pol_d;
            cnt_q      <= cnt_d;
            cmp_q      <= cmp_d;
            run_q      <= run_d;
            auto_q     <= auto_d;
            int_gen_q  <= |(pending_q & enable_q);
            rd_ack_q   <= WB_RD_STB_I;
            wr_ack_q   <= WB_WR_STB_I && WB_WR_WE_I;
            if (WB_RD_STB_I) rd_dat_q <= rd_val;
        end
    end

    assign WB_RD_DAT_O = rd_dat_q;
    assign WB_RD_ACK_O = rd_ack_q;
    assign WB_WR_ACK_O = wr_ack_q;
    assign int_gen     = int_gen_q;
    assign int_pending = pending_q;

endmodule

// File: tb/tb_intx_timer_irq_ctrl.sv
// Bench for intx_timer_irq_ctrl: register vector table plus hand sequences for channel,
// timer and reset behaviour; read data is checked through an expectation queue.
module tb_intx_timer_irq_ctrl;

    localparam int BASE = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sync_reset = 1'b0;
    logic        WB_RD_STB_I = 1'b0;
    logic [7:0]  WB_RD_ADR_I = '0;
    logic [31:0] WB_RD_DAT_O;
    logic        WB_RD_ACK_O;
    logic        WB_WR_STB_I = 1'b0;
    logic        WB_WR_WE_I = 1'b0;
    logic [3:0]  WB_WR_SEL_I = '0;
    logic [7:0]  WB_WR_ADR_I = '0;
    logic [31:0] WB_WR_DAT_I = '0;
    logic        WB_WR_ACK_O;
    logic [3:0]  INTx = '0;
    logic        int_gen;
    logic [4:0]  int_pending;

    intx_timer_irq_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sync_reset  (sync_reset),
        .WB_RD_STB_I (WB_RD_STB_I),
        .WB_RD_ADR_I (WB_RD_ADR_I),
        .WB_RD_DAT_O (WB_RD_DAT_O),
        .WB_RD_ACK_O (WB_RD_ACK_O),
        .WB_WR_STB_I (WB_WR_STB_I),
        .WB_WR_WE_I  (WB_WR_WE_I),
        .WB_WR_SEL_I (WB_WR_SEL_I),
        .WB_WR_ADR_I (WB_WR_ADR_I),
        .WB_WR_DAT_I (WB_WR_DAT_I),
        .WB_WR_ACK_O (WB_WR_ACK_O),
        .INTx        (INTx),
        .int_gen     (int_gen),
        .int_pending (int_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          woff;
        logic [31:0] wdat;
        logic [3:0]  sel;
        int          roff;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[17];
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_pass = 0;
    int          n_total = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_issue(input int off, input logic [31:0] e, input string nm);
        WB_RD_STB_I = 1'b1;
        WB_RD_ADR_I = 8'(BASE + off);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic rd_collect();
        logic [31:0] e;
        string       nm;
        if (exp_q.size() == 0) begin
            check("rd_ack_unexpected", 32'(WB_RD_ACK_O), 32'd0);
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check({nm, "_ack"}, 32'(WB_RD_ACK_O), 32'd1);
            check(nm, WB_RD_DAT_O, e);
        end
    endtask

    task automatic rd(input int off, input logic [31:0] e, input string nm);
        rd_issue(off, e, nm);
        tick();
        WB_RD_STB_I = 1'b0;
        rd_collect();
    endtask

    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] sel);
        WB_WR_STB_I = 1'b1;
        WB_WR_WE_I  = 1'b1;
        WB_WR_SEL_I = sel;
        WB_WR_ADR_I = 8'(BASE + off);
        WB_WR_DAT_I = d;
        tick();
        WB_WR_STB_I = 1'b0;
        WB_WR_WE_I  = 1'b0;
        check($sformatf("wr_ack_off%0d", off), 32'(WB_WR_ACK_O), 32'd1);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_int_gen"}, 32'(int_gen), 32'd0);
        check({nm, "_pending"}, 32'(int_pending), 32'd0);
        check({nm, "_rd_ack"}, 32'(WB_RD_ACK_O), 32'd0);
        check({nm, "_wr_ack"}, 32'(WB_WR_ACK_O), 32'd0);
        check({nm, "_rd_dat"}, WB_RD_DAT_O, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    initial begin
        int          mcnt;
        logic        mpend;
        logic        hit;

        // {write offset, write data, byte enables, read offset, expected read}
        vecs[0]  = '{1, 32'hFFFF_FFFF, 4'hF, 1, 32'h0000_001F};
        vecs[1]  = '{1, 32'h0000_0000, 4'h2, 1, 32'h0000_001F};
        vecs[2]  = '{1, 32'hFFFF_FFE0, 4'h1, 1, 32'h0000_0000};
        vecs[3]  = '{1, 32'hFFFF_FFFF, 4'h1, 1, 32'h0000_001F};
        vecs[4]  = '{1, 32'h0000_0000, 4'hF, 1, 32'h0000_0000};
        vecs[5]  = '{2, 32'hFFFF_FFFF, 4'hF, 2, 32'h0000_000F};
        vecs[6]  = '{2, 32'h0000_0000, 4'hF, 2, 32'h0000_0000};
        vecs[7]  = '{3, 32'h0000_00A5, 4'hF, 3, 32'h0000_0005};
        vecs[8]  = '{3, 32'h0000_0000, 4'hF, 3, 32'h0000_0000};
        vecs[9]  = '{5, 32'h1234_5678, 4'hF, 5, 32'h1234_5678};
        vecs[10] = '{5, 32'hAABB_CCDD, 4'h4, 5, 32'h12BB_5678};
        vecs[11] = '{5, 32'h0000_0000, 4'hF, 5, 32'h0000_0000};
        vecs[12] = '{6, 32'hFFFF_FFFC, 4'hF, 6, 32'h0000_0000};
        vecs[13] = '{4, 32'hFFFF_FFFF, 4'hF, 4, 32'h0000_0000};
        vecs[14] = '{7, 32'hFFFF_FFFF, 4'hF, 1, 32'h0000_0000};
        vecs[15] = '{-1, 32'hFFFF_FFFF, 4'hF, 2, 32'h0000_0000};
        vecs[16] = '{0, 32'hFFFF_FFFF, 4'hF, 7, 32'h0000_0000};

        // Power-on reset
        repeat (2) tick();
        check_all_zero("por");
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) rd(i, 32'd0, $sformatf("por_rd%0d", i));

        for (int i = 0; i < 17; i++) begin
            wr(vecs[i].woff, vecs[i].wdat, vecs[i].sel);
            rd(vecs[i].roff, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Edge mode, channel 0
        wr(2, 32'h1, 4'hF);
        wr(1, 32'h1, 4'hF);
        INTx[0] = 1'b1;
        tick();
        INTx[0] = 1'b0;
        tick();
        check("edge_pend_e2", 32'(int_pending), 32'h0);
        tick();
        check("edge_pend_e3", 32'(int_pending), 32'h1);
        check("edge_gen_e3", 32'(int_gen), 32'd0);
        tick();
        check("edge_gen_e4", 32'(int_gen), 32'd1);
        rd(0, 32'h1, "edge_rd_pend");
        wr(0, 32'h1, 4'hF);
        check("edge_w1c_pend", 32'(int_pending), 32'h0);
        check("edge_w1c_gen_same", 32'(int_gen), 32'd1);
        tick();
        check("edge_w1c_gen_next", 32'(int_gen), 32'd0);
        // Edge arrives on the same edge as the clear
        INTx[0] = 1'b1;
        tick();
        INTx[0] = 1'b0;
        tick();
        wr(0, 32'h1, 4'hF);
        check("edge_set_wins", 32'(int_pending), 32'h1);
        wr(0, 32'h1, 4'h0);
        check("edge_w1c_sel0", 32'(int_pending), 32'h1);
        wr(0, 32'h1, 4'h1);
        check("edge_w1c_again", 32'(int_pending), 32'h0);

        // Level mode, active low, channel 2
        INTx[2] = 1'b1;
        wr(2, 32'h0, 4'hF);
        wr(3, 32'h4, 4'hF);
        wr(1, 32'h4, 4'hF);
        tick();
        check("lvl_idle", 32'(int_pending), 32'h0);
        INTx[2] = 1'b0;
        tick();
        tick();
        check("lvl_pend_e2", 32'(int_pending), 32'h0);
        tick();
        check("lvl_pend_e3", 32'(int_pending), 32'h4);
        tick();
        check("lvl_gen_e4", 32'(int_gen), 32'd1);
        wr(0, 32'h4, 4'hF);
        check("lvl_w1c_ineffective", 32'(int_pending), 32'h4);
        repeat (4) tick();
        check("lvl_hold", 32'(int_pending), 32'h4);
        INTx[2] = 1'b1;
        tick();
        tick();
        check("lvl_deassert_e2", 32'(int_pending), 32'h4);
        tick();
        check("lvl_deassert_e3", 32'(int_pending), 32'h0);
        tick();
        check("lvl_gen_off", 32'(int_gen), 32'd0);
        wr(1, 32'h0, 4'hF);
        INTx[2] = 1'b0;
        wr(3, 32'h0, 4'hF);
        repeat (3) tick();
        check("lvl_cleanup", 32'(int_pending), 32'h0);

        // Timer auto-reload, CMP=4: back-to-back CNT reads against a counter model
        wr(5, 32'd4, 4'hF);
        wr(1, 32'h10, 4'hF);
        wr(6, 32'h3, 4'hF);
        mcnt  = 0;
        mpend = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            rd_issue(4, 32'(mcnt), $sformatf("auto_cnt%0d", i));
            if (i == 7) begin
                WB_WR_STB_I = 1'b1;
                WB_WR_WE_I  = 1'b1;
                WB_WR_SEL_I = 4'hF;
                WB_WR_ADR_I = 8'(BASE);
                WB_WR_DAT_I = 32'h10;
            end
            tick();
            WB_RD_STB_I = 1'b0;
            WB_WR_STB_I = 1'b0;
            WB_WR_WE_I  = 1'b0;
            hit   = (mcnt == 4);
            mpend = hit | (mpend & (i != 7));
            mcnt  = hit ? 0 : mcnt + 1;
            rd_collect();
            check($sformatf("auto_pend%0d", i), 32'(int_pending[4]), 32'(mpend));
        end
        wr(6, 32'h0, 4'hF);
        wr(0, 32'h10, 4'hF);
        check("auto_stop_clear", 32'(int_pending), 32'h0);

        // Timer one-shot, CMP=2
        wr(5, 32'd2, 4'hF);
        wr(6, 32'h1, 4'hF);
        tick();
        tick();
        check("oneshot_e2", 32'(int_pending[4]), 32'd0);
        tick();
        check("oneshot_e3", 32'(int_pending[4]), 32'd1);
        rd(6, 32'h0, "oneshot_ctrl");
        rd(4, 32'd2, "oneshot_cnt");
        repeat (3) tick();
        rd(4, 32'd2, "oneshot_cnt_hold");
        check("oneshot_gen", 32'(int_gen), 32'd1);

        // CMP write mid-count restarts the counter
        wr(0, 32'h10, 4'hF);
        wr(5, 32'd10, 4'hF);
        wr(6, 32'h1, 4'hF);
        repeat (3) tick();
        rd(4, 32'd3, "midcnt_before");
        wr(5, 32'd10, 4'hF);
        rd_issue(4, 32'd0, "midcnt_after0");
        tick();
        rd_collect();
        rd_issue(4, 32'd1, "midcnt_after1");
        tick();
        WB_RD_STB_I = 1'b0;
        rd_collect();
        wr(6, 32'h0, 4'hF);

        // CTRL write on the match edge keeps RUN
        wr(5, 32'd2, 4'hF);
        wr(6, 32'h1, 4'hF);
        tick();
        tick();
        wr(6, 32'h1, 4'hF);
        rd(6, 32'h1, "ctrl_beats_match");
        wr(6, 32'h0, 4'hF);
        wr(0, 32'h10, 4'hF);

        // Asynchronous reset during traffic
        wr(1, 32'h1F, 4'hF);
        wr(5, 32'd0, 4'hF);
        wr(6, 32'h3, 4'hF);
        repeat (3) tick();
        check("arst_pre_gen", 32'(int_gen), 32'd1);
        rd_issue(1, 32'h1F, "arst_pre_rd");
        tick();
        rd_collect();
        reset_n = 1'b0;
        #1;
        check_all_zero("arst");
        tick();
        check_all_zero("arst_hold");
        reset_n     = 1'b1;
        WB_RD_STB_I = 1'b0;
        tick();
        check("arst_post_gen", 32'(int_gen), 32'd0);
        check("arst_post_pend", 32'(int_pending), 32'd0);
        for (int i = 0; i < 7; i++) rd(i, 32'd0, $sformatf("arst_rd%0d", i));

        // Synchronous reset
        wr(1, 32'h10, 4'hF);
        wr(5, 32'd0, 4'hF);
        wr(6, 32'h3, 4'hF);
        repeat (3) tick();
        check("srst_pre_gen", 32'(int_gen), 32'd1);
        sync_reset = 1'b1;
        tick();
        check("srst_gen", 32'(int_gen), 32'd0);
        check("srst_pend", 32'(int_pending), 32'd0);
        sync_reset = 1'b0;
        tick();
        check("srst_post_gen", 32'(int_gen), 32'd0);
        check("srst_post_pend", 32'(int_pending), 32'd0);
        rd(6, 32'h0, "srst_ctrl");
        rd(1, 32'h0, "srst_enable");
        rd(5, 32'h0, "srst_cmp");

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/intx_timer_irq_ctrl.md
# intx_timer_irq_ctrl

Parametrised interrupt controller for the MCU peripheral space. It succeeds the fixed, always-zero interrupt stub with four things: NUM_INTX synchronised external interrupt lines with per-channel edge/level and polarity selection, a compare timer, write-1-to-clear pending bits, and a single registered `int_gen` request to the core. It sits on the same dual-channel Wishbone register bus (FASM synchronous-RAM model) as the UART TX registers.

## Interface
- NUM_INTX, 4, number of external interrupt lines; legal range 1..31.
- XLEN, 32, data width.
- ADDR_BITS, 8, register address width (word addresses).
- BASE_ADDR, 8'h10, address of register 0; registers occupy BASE_ADDR+0..+6.

- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- sync_reset  in  1  synchronous reset, active high; same reset values as reset_n.
- WB_RD_STB_I  in  1  read strobe.
- WB_RD_ADR_I  in  ADDR_BITS  read address.
- WB_RD_DAT_O  out  XLEN  registered read data.
- WB_RD_ACK_O  out  1  read ack.
- WB_WR_STB_I  in  1  write strobe.
- WB_WR_WE_I  in  1  write enable; a write occurs when STB & WE are both high.
- WB_WR_SEL_I  in  XLEN/8  byte enables.
- WB_WR_ADR_I  in  ADDR_BITS  write address.
- WB_WR_DAT_I  in  XLEN  write data.
- WB_WR_ACK_O  out  1  write ack.
- INTx  in  NUM_INTX  asynchronous external interrupt lines.
- int_gen  out  1  registered interrupt request to the core.
- int_pending  out  NUM_INTX+1  current pending vector; bit NUM_INTX is the timer.

## Operation
**Register map (offset from BASE_ADDR)**
- 0 PENDING: read gives the pending vector. Write-1-to-clear, edge channels and timer bit only.
- 1 ENABLE: R/W, NUM_INTX+1 bits.
- 2 MODE: R/W; 1 = rising-edge (after polarity), 0 = level.
- 3 POLARITY: R/W; 1 = active low.
- 4 TIMER_CNT: read-only, XLEN-bit counter.
- 5 TIMER_CMP: R/W. Any write also zeroes TIMER_CNT.
- 6 TIMER_CTRL: R/W. bit0 RUN, bit1 AUTO_RELOAD.

**Register access rules**
- Unused register bits read 0.
- Unmapped addresses read 0; writes to them are ignored.
- WB_WR_SEL_I gates each byte of the R/W registers and of the PENDING clear mask.

**Channel path**
- Each INTx bit passes through a 2-flop synchroniser, then XOR with POLARITY, giving `lvl`.
- Edge mode: the pending bit is set when `lvl` goes 0→1, using a registered previous-`lvl` flop. It holds until W1C.
- Level mode: the pending bit equals `lvl` every cycle; W1C has no lasting effect.
- A set and a W1C of the same bit in the same cycle: set wins.

**Timer**
- While RUN=1, TIMER_CNT increments by 1 each cycle.
- When TIMER_CNT == TIMER_CMP with RUN=1, the timer pending bit is set and the counter is updated:
  - AUTO_RELOAD=1: TIMER_CNT becomes 0 on the next cycle.
  - AUTO_RELOAD=0: TIMER_CNT holds and RUN clears to 0.
- Counter increment wraps modulo 2^XLEN.
- A CMP write while running restarts the count from 0.
- A CTRL write in the same cycle as a match takes precedence for RUN.

**Interrupt output**
- int_gen <= |(pending & ENABLE), registered.

## Timing
- Reset (either reset) clears every output and register to 0: WB_RD_DAT_O, both acks, int_gen, int_pending, ENABLE/MODE/POLARITY/CMP/CTRL/CNT, synchronisers and edge flops.
- A reset applied mid-operation discards all pending state with no residual interrupt.
- WB_RD_ACK_O and WB_RD_DAT_O are valid 1 cycle after WB_RD_STB_I. Read data reflects register state at the strobe edge.
- WB_WR_ACK_O is asserted 1 cycle after STB&WE. The register update is visible on that same edge.
- Back-to-back strobes on consecutive cycles are supported; there are no wait states.
- Edge-mode latency: an INTx change at cycle 0 sets the pending bit at edge 3 (2 sync + 1 edge detect). int_gen follows at edge 4.
- Level mode has the same latency on both assertion and deassertion.
- Timer: with CMP=N and RUN written at cycle 0, pending sets N+1 edges later. Auto-reload period = N+1 cycles.
- A W1C of an edge bit at edge k drops int_gen at edge k+1, unless a new edge arrives.

## Test plan
- Reset: assert reset_n low mid-traffic → all outputs 0. After release, read offsets 0..6 → all 0, ack 1 cycle after each strobe.
- Edge mode, ch0, MODE=1, ENABLE=1: pulse INTx[0] high 1 cycle → PENDING=0x1 at +3, int_gen=1 at +4. W1C 0x1 → int_gen=0 next cycle. Edge landing on the clear cycle → bit stays 1.
- Level mode, active low, ch2: POLARITY=0x4, ENABLE=0x4; drive INTx[2]=0 for 10 cycles → pending bit 2 = 1 during that window (shifted +3), W1C ineffective. Return INTx[2] high → bit 2 clears 3 cycles later.
- Timer, auto-reload: CMP=4, CTRL=0x3, ENABLE bit NUM_INTX → pending set every 5 cycles. CNT reads 0..4 cyclically.
- Timer, one-shot: CMP=2, CTRL=0x1 → one set, CTRL reads 0, CNT holds 2. Writing CMP mid-count resets CNT to 0.
- Byte enables: write ENABLE=0xFFFFFFFF with SEL=4'b0001 → reads back (0xFF & mask). Write to unmapped BASE_ADDR+7 → no register change, ack still 1.
